// File: rtl/gpt_pkg.sv
// Shared timer package: capture polarity encoding, filter code width and
// the edge qualification helper used by the capture channels.
package gpt_pkg;

  localparam int ICF_W = 4;

  typedef enum logic [1:0] {
    IC_POL_RISE = 2'b00,
    IC_POL_FALL = 2'b01,
    IC_POL_RSVD = 2'b10,
    IC_POL_BOTH = 2'b11
  } ic_pol_e;

  // Qualify a level change against the selected polarity; the reserved code
  // behaves as rising so an unprogrammed channel still does something sane.
  function automatic logic ic_edge_hit(input ic_pol_e pol, input logic cur,
                                       input logic prev);
    logic rise;
    logic fall;
    logic hit;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (pol)
      IC_POL_FALL: hit = fall;
      IC_POL_BOTH: hit = rise | fall;
      default:     hit = rise;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/input_capture_filter_if.sv
// Bundle of the capture channel signals between a pin/control source and the
// input capture filter.
interface input_capture_filter_if;
  import gpt_pkg::*;

  logic             ti;
  logic             cce;
  logic [ICF_W-1:0] icf;
  logic [1:0]       icp;
  logic             ti_filt;
  logic             ic;

  modport master (output ti, cce, icf, icp, input ti_filt, ic);
  modport slave  (input ti, cce, icf, icp, output ti_filt, ic);
endinterface

// File: rtl/input_capture_filter_sync_ff.sv
// Multi-flop synchronizer bringing the asynchronous timer pin into clk_i.
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic aresetn_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb sync_d = {sync_q[DEPTH-2:0], d_i};

  // Shift the pin through the synchronizer chain.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) sync_q <= '0;
    else            sync_q <= sync_d;
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/input_capture_filter.sv
// Timer input capture front end: pin synchronizer, digital glitch filter of
// icf_i+1 consecutive samples, and a polarity-selected one-cycle capture
// strobe. Define TI_SYNC3_EN for a 3-flop synchronizer (one extra cycle of
// latency everywhere).
module input_capture_filter
  import gpt_pkg::*;
(
  input  logic             clk_i,
  input  logic             aresetn_i,
  input  logic             ti_i,
  input  logic             cce_i,
  input  logic [ICF_W-1:0] icf_i,
  input  logic [1:0]       icp_i,
  output logic             ti_filt_o,
  output logic             ic_o
);

`ifdef TI_SYNC3_EN
  localparam int SYNC_DEPTH = 3;
`else
  localparam int SYNC_DEPTH = 2;
`endif

  logic             ti_sync;
  logic [ICF_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;
  logic             prev_q;
  logic             ic_q, ic_d;

  sync_ff #(.DEPTH(SYNC_DEPTH)) u_sync (
    .clk_i     (clk_i),
    .aresetn_i (aresetn_i),
    .d_i       (ti_i),
    .q_o       (ti_sync)
  );

  // Filter: count consecutive disagreeing samples; the >= compare lets a
  // shrinking icf_i take effect immediately instead of wrapping the counter.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (ti_sync == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q >= icf_i) begin
      filt_d = ti_sync;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Capture strobe: edge of the filtered level versus last cycle, gated by
  // the channel enable so nothing is remembered while disabled.
  always_comb ic_d = cce_i & ic_edge_hit(ic_pol_e'(icp_i), filt_q, prev_q);

  // Filter state, edge history and registered strobe.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
      prev_q <= 1'b0;
      ic_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      prev_q <= filt_q;
      ic_q   <= ic_d;
    end
  end

  assign ti_filt_o = filt_q;
  assign ic_o      = ic_q;

endmodule

// File: tb/tb_input_capture_filter.sv
// Directed bench for input_capture_filter: latency, glitch rejection,
// polarity, enable gating, mid-count icf change and asynchronous reset.
module tb_input_capture_filter;

`ifdef TI_SYNC3_EN
  localparam int E = 1;
`else
  localparam int E = 0;
`endif

  logic clk_i = 1'b0;
  logic aresetn_i;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;
  logic tlev;

  input_capture_filter_if bus ();

  input_capture_filter dut (
    .clk_i     (clk_i),
    .aresetn_i (aresetn_i),
    .ti_i      (bus.ti),
    .cce_i     (bus.cce),
    .icf_i     (bus.icf),
    .icp_i     (bus.icp),
    .ti_filt_o (bus.ti_filt),
    .ic_o      (bus.ic)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rising edge on ti with icf=0: filt after edge 2, ic only after edge 3.
  task automatic run_basic(input string tag);
    bus.ti = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk_i);
      check({tag, "_filt"}, {7'd0, bus.ti_filt}, 8'(k >= 2 + E));
      check({tag, "_ic"},   {7'd0, bus.ic},      8'(k == 3 + E));
    end
  endtask

  initial begin
    bus.ti  = 1'b0;
    bus.cce = 1'b0;
    bus.icf = 4'd0;
    bus.icp = 2'b00;
    aresetn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_filt", {7'd0, bus.ti_filt}, 8'd0);
    check("rst_ic",   {7'd0, bus.ic},      8'd0);
    check("rst_cnt",  {4'd0, dut.cnt_q},   8'd0);
    aresetn_i = 1'b1;
    repeat (4) @(negedge clk_i);

    // icf=0 pass-through, rising polarity
    bus.cce = 1'b1;
    run_basic("basic");
    bus.ti = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk_i);
      check("basic_fall_noic", {7'd0, bus.ic}, 8'd0);
    end

    // icf=3: 3-sample pulse rejected completely
    bus.icf = 4'd3;
    bus.ti  = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk_i);
      check("short_filt", {7'd0, bus.ti_filt}, 8'd0);
      check("short_ic",   {7'd0, bus.ic},      8'd0);
      if (k == 2) bus.ti = 1'b0;
    end

    // icf=3: 4-sample pulse passes, ic at edge 6
    bus.ti = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk_i);
      check("long_filt", {7'd0, bus.ti_filt}, 8'(k >= 5 + E && k < 9 + E));
      check("long_ic",   {7'd0, bus.ic},      8'(k == 6 + E));
      if (k == 3) bus.ti = 1'b0;
    end

    // polarity change alone never fires
    bus.icp = 2'b11;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk_i);
      check("icp_chg_noic", {7'd0, bus.ic}, 8'd0);
    end

    // both edges, icf=2, 20-cycle square wave: ic 5 edges after each ti edge
    bus.icf = 4'd2;
    tlev = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (n % 10 == 0) begin
        tlev   = ~tlev;
        bus.ti = tlev;
      end
      @(negedge clk_i);
      check("sq_ic",   {7'd0, bus.ic},      8'((n % 10) == 5 + E));
      check("sq_filt", {7'd0, bus.ti_filt}, {7'd0, ((n % 10) >= 4 + E) ? tlev : ~tlev});
    end

    // cce=0 gates ic but filter keeps tracking; no retroactive pulse
    bus.icf = 4'd0;
    bus.cce = 1'b0;
    bus.ti  = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk_i);
      check("cce0_ic",   {7'd0, bus.ic},      8'd0);
      check("cce0_filt", {7'd0, bus.ti_filt}, 8'(k >= 2 + E));
    end
    bus.cce = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk_i);
      check("cce1_noretro", {7'd0, bus.ic}, 8'd0);
    end
    bus.ti = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk_i);
      check("cce1_fall_ic", {7'd0, bus.ic}, 8'(k == 3 + E));
    end

    // cnt reaches 7 with icf=9, then icf drops to 2: update on next sample
    bus.icf = 4'd9;
    bus.ti  = 1'b1;
    for (int k = 0; k <= 10 + E; k++) begin
      @(negedge clk_i);
      if (k == 8 + E) begin
        check("icf_cnt7", {4'd0, dut.cnt_q}, 8'd7);
        bus.icf = 4'd2;
      end
      if (k == 9 + E) check("icf_cnt0", {4'd0, dut.cnt_q}, 8'd0);
      check("icf_filt", {7'd0, bus.ti_filt}, 8'(k >= 9 + E));
      check("icf_ic",   {7'd0, bus.ic},      8'(k == 10 + E));
    end

    // asynchronous reset in the middle of a filter count
    bus.icf = 4'd9;
    bus.ti  = 1'b0;
    repeat (6) @(negedge clk_i);
    check("pre_rst_filt", {7'd0, bus.ti_filt}, 8'd1);
    @(posedge clk_i);
    #2 aresetn_i = 1'b0;
    #1;
    check("async_rst_filt", {7'd0, bus.ti_filt}, 8'd0);
    check("async_rst_ic",   {7'd0, bus.ic},      8'd0);
    check("async_rst_cnt",  {4'd0, dut.cnt_q},   8'd0);
    @(negedge clk_i);
    aresetn_i = 1'b1;
    bus.icf = 4'd0;
    bus.icp = 2'b00;
    repeat (2) @(negedge clk_i);
    run_basic("post_rst");

    // reserved polarity code behaves as rising
    bus.ti = 1'b0;
    repeat (6) @(negedge clk_i);
    bus.icp = 2'b10;
    run_basic("rsvd_rise");
    bus.ti = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk_i);
      check("rsvd_fall_noic", {7'd0, bus.ic}, 8'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
